// File: rtl/sfx_sequencer.sv
// Game-event sound-effect sequencer. It turns one-cycle event pulses into a
// timed series of note requests (12-bit frequency plus a one-cycle strobe)
// for the downstream tone synthesizer.
`timescale 1ns/1ps

module sfx_sequencer #(
    parameter int unsigned NOTE_CYCLES = 32'd60000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ev_eat,
    input  logic        ev_start,
    input  logic        ev_die,
    output logic [11:0] freq,
    output logic        note_strobe,
    output logic        busy,
    output logic [1:0]  melody,
    output logic [1:0]  note_idx
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned FREQ_W = 12;
    localparam int unsigned MEL_W  = 2;
    localparam int unsigned IDX_W  = 2;

    // Countdown reload. The strobe edge and the NOTE->HOLD edge account for
    // the other two cycles of the note period.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(NOTE_CYCLES - 32'd2);

    localparam logic [MEL_W-1:0] MEL_NONE  = 2'd0;
    localparam logic [MEL_W-1:0] MEL_EAT   = 2'd1;
    localparam logic [MEL_W-1:0] MEL_START = 2'd2;
    localparam logic [MEL_W-1:0] MEL_DIE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NOTE = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [MEL_W-1:0]   r_ev_mel;
    logic [MEL_W-1:0]   r_melody;
    logic [IDX_W-1:0]   r_idx;
    logic [FREQ_W-1:0]  r_freq;
    logic               r_strobe;
    logic               r_busy;

    logic [MEL_W-1:0]   w_ev_mel;
    logic               w_preempt;
    logic               w_last;
    logic [IDX_W-1:0]   w_next_idx;
    logic [FREQ_W-1:0]  w_first_freq;
    logic [FREQ_W-1:0]  w_next_freq;

    // Note ROM indexed by (melody, note index).
    function automatic logic [FREQ_W-1:0] rom_freq(input logic [MEL_W-1:0] m,
                                                   input logic [IDX_W-1:0] i);
        logic [FREQ_W-1:0] f;
        f = '0;
        case ({m, i})
            {MEL_EAT,   2'd0}: f = 12'd880;
            {MEL_START, 2'd0}: f = 12'd440;
            {MEL_START, 2'd1}: f = 12'd554;
            {MEL_START, 2'd2}: f = 12'd659;
            {MEL_DIE,   2'd0}: f = 12'd659;
            {MEL_DIE,   2'd1}: f = 12'd523;
            {MEL_DIE,   2'd2}: f = 12'd440;
            {MEL_DIE,   2'd3}: f = 12'd330;
            default:           f = '0;
        endcase
        return f;
    endfunction

    // Index of the final note of each melody.
    function automatic logic [IDX_W-1:0] last_idx(input logic [MEL_W-1:0] m);
        logic [IDX_W-1:0] l;
        l = '0;
        case (m)
            MEL_START: l = 2'd2;
            MEL_DIE:   l = 2'd3;
            default:   l = 2'd0;
        endcase
        return l;
    endfunction

    // Event priority encoder: die > start > eat.
    always_comb begin
        w_ev_mel = MEL_NONE;
        if (ev_die) begin
            w_ev_mel = MEL_DIE;
        end else if (ev_start) begin
            w_ev_mel = MEL_START;
        end else if (ev_eat) begin
            w_ev_mel = MEL_EAT;
        end
    end

    // Start/preempt decision and ROM lookups for the next strobe.
    always_comb begin
        w_preempt    = (r_ev_mel > r_melody);
        w_last       = (r_idx == last_idx(r_melody));
        w_next_idx   = r_idx + 2'd1;
        w_first_freq = rom_freq(r_ev_mel, 2'd0);
        w_next_freq  = rom_freq(r_melody, w_next_idx);
    end

    // Event capture; a captured event is compared against the melody that is
    // active after the same edge, so an event on the edge busy falls restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev_mel <= MEL_NONE;
        end else begin
            r_ev_mel <= w_ev_mel;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_melody <= MEL_NONE;
            r_idx    <= '0;
            r_freq   <= '0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_preempt) begin
                // New melody (from idle or higher-priority abort) wins over
                // any countdown activity this cycle.
                r_state  <= S_NOTE;
                r_melody <= r_ev_mel;
                r_idx    <= '0;
                r_freq   <= w_first_freq;
                r_strobe <= 1'b1;
                r_busy   <= 1'b1;
                r_count  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_NOTE: begin
                        r_state <= S_HOLD;
                        r_count <= LOAD_VAL;
                    end
                    S_HOLD: begin
                        if (r_count == '0) begin
                            if (w_last) begin
                                r_state  <= S_IDLE;
                                r_melody <= MEL_NONE;
                                r_idx    <= '0;
                                r_freq   <= '0;
                                r_busy   <= 1'b0;
                            end else begin
                                r_state  <= S_NOTE;
                                r_idx    <= w_next_idx;
                                r_freq   <= w_next_freq;
                                r_strobe <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count - 32'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign freq        = r_freq;
    assign note_strobe = r_strobe;
    assign busy        = r_busy;
    assign melody      = r_melody;
    assign note_idx    = r_idx;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random events, every cycle
// compared with a timeline model (melody start edge + note table arithmetic).
`timescale 1ns/1ps

module tb_sfx_sequencer;

    localparam int unsigned N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev_eat, ev_start, ev_die;
    logic [11:0] freq;
    logic        note_strobe, busy;
    logic [1:0]  melody, note_idx;

    int n_vec = 0;
    int n_err = 0;

    // Model: active melody and the edge number of its first strobe.
    int      m_mel = 0;
    longint  m_t0  = 0;
    longint  e_cnt = 0;
    int      notes [4][4] = '{'{0, 0, 0, 0}, '{880, 0, 0, 0},
                              '{440, 554, 659, 0}, '{659, 523, 440, 330}};
    int      lens [4] = '{0, 1, 3, 4};

    sfx_sequencer #(.NOTE_CYCLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ev_eat      (ev_eat),
        .ev_start    (ev_start),
        .ev_die      (ev_die),
        .freq        (freq),
        .note_strobe (note_strobe),
        .busy        (busy),
        .melody      (melody),
        .note_idx    (note_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e_cnt, obs, exp);
        end
    endtask

    task automatic chk_all(input int x_freq, input int x_stb, input int x_busy,
                           input int x_mel, input int x_idx);
        chk("freq",        32'(freq),        32'(x_freq));
        chk("note_strobe", 32'(note_strobe), 32'(x_stb));
        chk("busy",        32'(busy),        32'(x_busy));
        chk("melody",      32'(melody),      32'(x_mel));
        chk("note_idx",    32'(note_idx),    32'(x_idx));
    endtask

    // One clock: drive events, sample edge, compare, then let the model take
    // the events that were sampled on this edge.
    task automatic tick(input logic e, input logic s, input logic d);
        longint rel;
        int x_freq, x_stb, x_busy, x_mel, x_idx, ep;
        ev_eat = e; ev_start = s; ev_die = d;
        @(posedge clk);
        e_cnt++;
        #1;
        if (!rst_n) m_mel = 0;
        rel = e_cnt - m_t0;
        if (m_mel != 0 && rel >= 0 && rel < longint'(lens[m_mel]) * N) begin
            x_idx  = int'(rel / N);
            x_freq = notes[m_mel][x_idx];
            x_stb  = (rel % N == 0) ? 1 : 0;
            x_busy = 1;
            x_mel  = m_mel;
        end else begin
            m_mel = 0;
            x_idx = 0; x_freq = 0; x_stb = 0; x_busy = 0; x_mel = 0;
        end
        chk_all(x_freq, x_stb, x_busy, x_mel, x_idx);
        ep = d ? 3 : s ? 2 : e ? 1 : 0;
        if (rst_n && ep > x_mel) begin
            m_mel = ep;
            m_t0  = e_cnt + 1;
        end
        ev_eat = 1'b0; ev_start = 1'b0; ev_die = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Pull reset between edges and confirm outputs clear before the next edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(0, 0, 0, 0, 0);
        m_mel = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        ev_eat = 1'b0; ev_start = 1'b0; ev_die = 1'b0;

        // Reset held with random events.
        for (int i = 0; i < 6; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rst_n = 1'b1;
        run(100);

        // Single eat note.
        run(9);
        tick(1'b1, 1'b0, 1'b0);
        run(12);

        // Die melody, then all three events together.
        tick(1'b0, 1'b0, 1'b1);
        run(40);
        tick(1'b1, 1'b1, 1'b1);
        run(40);

        // Die preempts the second start note.
        tick(1'b0, 1'b1, 1'b0);
        run(11);
        tick(1'b0, 1'b0, 1'b1);
        run(40);

        // Eat during die is dropped; repeated start during start is dropped.
        tick(1'b0, 1'b0, 1'b1);
        run(10);
        tick(1'b1, 1'b0, 1'b0);
        run(30);
        tick(1'b0, 1'b1, 1'b0);
        run(5);
        tick(1'b0, 1'b1, 1'b0);
        run(30);

        // Event sampled on the edge busy falls restarts immediately.
        tick(1'b1, 1'b0, 1'b0);
        run(8);
        tick(1'b0, 1'b1, 1'b0);
        run(30);

        // Asynchronous reset during the second start note.
        tick(1'b0, 1'b1, 1'b0);
        run(10);
        async_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
        rst_n = 1'b1;
        run(3);
        tick(1'b1, 1'b0, 1'b0);
        run(15);

        // Random events with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                rst_n = 1'b1;
            end else begin
                tick(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 25) == 0),
                     1'($urandom_range(0, 40) == 0));
            end
        end
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
